// File: rtl/matrix_reg_sequencer.sv
// ============================================================================
// Module  : matrix_reg_sequencer
// Brief   : Bus master that reads operands A/B from the matrix register bank,
//           issues them to the matrix ALU and writes the result back.
//           Optional macro MATRIX_READBACK_CHECK_EN adds a write read-back check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_reg_sequencer #(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              cmd_wb,
    output logic              reg_en,
    output logic              reg_rw,
    output logic [ADDR_W-1:0] reg_address,
    output logic [DATA_W-1:0] reg_datain,
    input  logic [DATA_W-1:0] reg_dataout,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] C_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAP_B,
        S_ISSUE,
        S_WAIT_RES,
        S_WRITE,
`ifdef MATRIX_READBACK_CHECK_EN
        S_DONE,
        S_VERIFY_RD,
        S_VERIFY_CMP
`else
        S_DONE
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_a_q, src_a_d;
    logic [ADDR_W-1:0]   src_b_q, src_b_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic                wb_q, wb_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   datain_q, datain_d;
    logic                w_illegal;

    // Destination only matters when the result is actually written back.
    assign w_illegal = ({1'b0, cmd_src_a} >= C_NUM_REGS) ||
                       ({1'b0, cmd_src_b} >= C_NUM_REGS) ||
                       (cmd_wb && ({1'b0, cmd_dst} >= C_NUM_REGS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            wb_q     <= 1'b0;
            err_q    <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            datain_q <= '0;
        end else begin
            state_q  <= state_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            wb_q     <= wb_d;
            err_q    <= err_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            datain_q <= datain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        wb_d     = wb_q;
        err_d    = err_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        datain_d = datain_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    dst_d   = cmd_dst;
                    wb_d    = cmd_wb;
                    err_d   = w_illegal;
                    state_d = w_illegal ? S_DONE : S_RD_A;
                end
            end
            S_RD_A:  state_d = S_RD_B;
            S_RD_B: begin
                op_a_d  = reg_dataout;
                state_d = S_CAP_B;
            end
            S_CAP_B: begin
                op_b_d  = reg_dataout;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_ready) begin
                    if (res_valid) begin
                        if (wb_q) begin
                            datain_d = res_data;
                            state_d  = S_WRITE;
                        end else begin
                            state_d  = S_DONE;
                        end
                    end else begin
                        state_d = S_WAIT_RES;
                    end
                end
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    if (wb_q) begin
                        datain_d = res_data;
                        state_d  = S_WRITE;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
`ifdef MATRIX_READBACK_CHECK_EN
            S_WRITE:     state_d = S_VERIFY_RD;
            S_VERIFY_RD: state_d = S_VERIFY_CMP;
            S_VERIFY_CMP: begin
                err_d   = (reg_dataout != datain_q);
                state_d = S_DONE;
            end
`else
            S_WRITE:     state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode: everything below depends on registered state only.
    always_comb begin
        cmd_ready   = 1'b0;
        reg_en      = 1'b0;
        reg_rw      = 1'b1;
        reg_address = '0;
        op_valid    = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            S_IDLE:  cmd_ready = 1'b1;
            S_RD_A: begin
                reg_en      = 1'b1;
                reg_address = src_a_q;
            end
            S_RD_B: begin
                reg_en      = 1'b1;
                reg_address = src_b_q;
            end
            S_ISSUE: op_valid = 1'b1;
            S_WRITE: begin
                reg_en      = 1'b1;
                reg_rw      = 1'b0;
                reg_address = dst_q;
            end
`ifdef MATRIX_READBACK_CHECK_EN
            S_VERIFY_RD: begin
                reg_en      = 1'b1;
                reg_address = dst_q;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign reg_datain = datain_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_reg_sequencer.sv
// ============================================================================
// Module  : tb_matrix_reg_sequencer
// Brief   : Directed self-checking bench with register bank and ALU models.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matrix_reg_sequencer;

    localparam int DW = 256;
    localparam int AW = 2;
`ifdef MATRIX_READBACK_CHECK_EN
    localparam int C_LAT     = 8;
    localparam int C_WR2DONE = 3;
`else
    localparam int C_LAT     = 6;
    localparam int C_WR2DONE = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src_a = '0;
    logic [AW-1:0] cmd_src_b = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic          cmd_wb = 1'b0;
    logic          reg_en;
    logic          reg_rw;
    logic [AW-1:0] reg_address;
    logic [DW-1:0] reg_datain;
    logic [DW-1:0] reg_dataout = '0;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    matrix_reg_sequencer #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(3)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_dst    (cmd_dst),
        .cmd_wb     (cmd_wb),
        .reg_en     (reg_en),
        .reg_rw     (reg_rw),
        .reg_address(reg_address),
        .reg_datain (reg_datain),
        .reg_dataout(reg_dataout),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .done       (done),
        .err        (err)
    );

    // Register bank model: 1-cycle read latency, optional corruption of R2 writes
    logic [DW-1:0] mem [0:3];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          corrupt = 1'b0;

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (reg_en && !reg_rw)
            mem[reg_address] <= (corrupt && reg_address == 2'd2) ? (reg_datain ^ 256'h1) : reg_datain;
        reg_dataout <= (reg_en && reg_rw) ? mem[reg_address] : '0;
    end

    // ALU model: ready after rdy_dly op_valid cycles, result res_dly cycles after handshake
    int            rdy_dly = 0;
    int            res_dly = 0;
    logic [DW-1:0] res_val = '0;
    int            vcnt = 0;
    int            rcnt = 0;
    logic          ractive = 1'b0;

    assign op_ready  = op_valid && (vcnt == rdy_dly);
    assign res_valid = (res_dly == 0) ? (op_valid && op_ready) : (ractive && rcnt == res_dly);
    assign res_data  = res_val;

    always @(posedge clk) begin
        if (rst) begin
            vcnt    <= 0;
            rcnt    <= 0;
            ractive <= 1'b0;
        end else begin
            vcnt <= (op_valid && !op_ready) ? vcnt + 1 : 0;
            if (op_valid && op_ready && res_dly != 0) begin
                ractive <= 1'b1;
                rcnt    <= 1;
            end else if (ractive) begin
                if (rcnt == res_dly) ractive <= 1'b0;
                else                 rcnt    <= rcnt + 1;
            end
        end
    end

    // Activity monitors
    int cyc = 0;
    int wr2_cnt = 0;
    int wr_cnt = 0;
    int en_cnt = 0;
    int ov_cnt = 0;
    int done_cnt = 0;
    int last_wr2_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reg_en) en_cnt <= en_cnt + 1;
        if (reg_en && !reg_rw) wr_cnt <= wr_cnt + 1;
        if (reg_en && !reg_rw && reg_address == 2'd2) begin
            wr2_cnt      <= wr2_cnt + 1;
            last_wr2_cyc <= cyc;
        end
        if (op_valid) ov_cnt <= ov_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Issues one command and returns cycles from accept to done (-1 on timeout).
    task automatic run_cmd(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                           input logic wb, output int lat, output logic e);
        @(negedge clk);
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = d;
        cmd_wb    = wb;
        cmd_valid = 1'b1;
        lat = -1;
        e   = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (done) begin
                lat = i;
                e   = err;
                break;
            end
        end
    endtask

    int   lat;
    logic e;
    int   snap_a, snap_b;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_reg_en", reg_en, 0);
        chk("rst_reg_rw", reg_rw, 1);
        chk("rst_reg_address", reg_address, 0);
        chk("rst_reg_datain", reg_datain, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_done_err", {done, err}, 0);
        rst = 1'b0;

        load(2'd0, 256'h1);
        load(2'd1, 256'h2);
        load(2'd2, 256'h0);

        // Best case
        rdy_dly = 0; res_dly = 0; res_val = 256'h3;
        snap_a = wr2_cnt;
        run_cmd(2'd0, 2'd1, 2'd2, 1'b1, lat, e);
        chk("t1_latency", lat, C_LAT);
        chk("t1_err", e, 0);
        chk("t1_op_a", op_a, 256'h1);
        chk("t1_op_b", op_b, 256'h2);
        chk("t1_r2", mem[2], 256'h3);
        chk("t1_wr2_count", wr2_cnt - snap_a, 1);

        // Delayed ready / result
        load(2'd2, 256'h0);
        rdy_dly = 3; res_dly = 5;
        snap_a = wr2_cnt;
        snap_b = ov_cnt;
        run_cmd(2'd0, 2'd1, 2'd2, 1'b1, lat, e);
        chk("t2_latency", lat, C_LAT + 8);
        chk("t2_op_valid_cycles", ov_cnt - snap_b, 4);
        chk("t2_wr2_count", wr2_cnt - snap_a, 1);
        chk("t2_write_to_done", cyc - last_wr2_cyc, C_WR2DONE);
        chk("t2_r2", mem[2], 256'h3);
        chk("t2_err", e, 0);

        // Same register as both sources and destination
        load(2'd1, 256'hA);
        rdy_dly = 0; res_dly = 0; res_val = 256'h14;
        run_cmd(2'd1, 2'd1, 2'd1, 1'b1, lat, e);
        chk("t3_op_a", op_a, 256'hA);
        chk("t3_op_b", op_b, 256'hA);
        chk("t3_r1", mem[1], 256'h14);
        chk("t3_latency", lat, C_LAT);

        // Illegal source address
        snap_a = en_cnt;
        run_cmd(2'd3, 2'd0, 2'd0, 1'b1, lat, e);
        chk("t4_latency", lat, 1);
        chk("t4_err", e, 1);
        chk("t4_no_reg_en", en_cnt - snap_a, 0);
        chk("t4_r0_unchanged", mem[0], 256'h1);

        // Illegal dst with wb=0 is fine; result discarded
        snap_a = wr_cnt;
        run_cmd(2'd0, 2'd0, 2'd3, 1'b0, lat, e);
        chk("t5_latency", lat, 5);
        chk("t5_err", e, 0);
        chk("t5_no_write", wr_cnt - snap_a, 0);

        // Reset while waiting for the result
        rdy_dly = 0; res_dly = 20;
        @(negedge clk);
        cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd2; cmd_wb = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_in_wait_res", {op_valid, cmd_ready}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_reg_en", reg_en, 0);
        chk("t6_op_a", op_a, 0);
        chk("t6_done", done, 0);
        snap_a = done_cnt;
        repeat (3) @(negedge clk);
        chk("t6_no_done", done_cnt - snap_a, 0);
        res_dly = 0; res_val = 256'h5;
        run_cmd(2'd1, 2'd0, 2'd2, 1'b1, lat, e);
        chk("t6_after_latency", lat, C_LAT);
        chk("t6_after_err", e, 0);
        chk("t6_after_op_a", op_a, 256'h14);
        chk("t6_after_r2", mem[2], 256'h5);

`ifdef MATRIX_READBACK_CHECK_EN
        // Corrupted write detected by read-back
        res_val = 256'h7;
        corrupt = 1'b1;
        run_cmd(2'd0, 2'd1, 2'd2, 1'b1, lat, e);
        chk("t7_corrupt_latency", lat, 8);
        chk("t7_corrupt_err", e, 1);
        corrupt = 1'b0;
        run_cmd(2'd0, 2'd1, 2'd2, 1'b1, lat, e);
        chk("t7_clean_err", e, 0);
        chk("t7_clean_r2", mem[2], 256'h7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
